rpn_stack_evaluator: RTL

Parametrised successor to the fixed-point stack machine. Evaluates a postfix (RPN) token sequence held in the output queue for one x sample and returns y. Adds a configurable stack depth, subtract/multiply/negate operators, saturating arithmetic and error reporting. Sits between the shunting-yard output queue and the plotter's per-column y computation.

---
 rtl/stack_machine_pkg.sv | 42 ++++
 rtl/rpn_stack_evaluator_if.sv | 30 +++
 rtl/fixed_point_alu.sv | 42 ++++
 rtl/rpn_stack_evaluator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/stack_machine_pkg.sv
// Shared constants for the RPN stack evaluator: opcodes, error codes, FSM states
// and fixed-point width/saturation helpers.
package stack_machine_pkg;

  localparam int DEF_INT_W  = 11;
  localparam int DEF_FRAC_W = 8;

  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_NEG   = 3'd4;
  localparam logic [2:0] OP_PUSHX = 3'd6;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_EMPTY     = 3'd1;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd3;
  localparam logic [2:0] ERR_OPCODE    = 3'd4;
  localparam logic [2:0] ERR_MALFORMED = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_CHECK
  } state_t;

  function automatic int fp_width(input int int_w, input int frac_w);
    return int_w + frac_w;
  endfunction

  function automatic logic signed [63:0] sat_max(input int n);
    return (64'sd1 <<< (n - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int n);
    return -(64'sd1 <<< (n - 1));
  endfunction

endpackage

// File: rtl/rpn_stack_evaluator_if.sv
// Token fetch bus between the evaluator (master) and the shunting-yard output queue.
interface rpn_stack_evaluator_if #(
  parameter int DATA_W     = 19,
  parameter int QUEUE_SIZE = 64
);
  localparam int IDX_W = $clog2(QUEUE_SIZE);
  localparam int LEN_W = $clog2(QUEUE_SIZE + 1);

  logic [IDX_W-1:0] output_queue_index;
  logic             output_queue_get;
  logic [LEN_W-1:0] output_queue_length;
  logic [DATA_W:0]  output_queue_data_out;
  logic             output_queue_ready;

  modport master (
    output output_queue_index,
    output output_queue_get,
    input  output_queue_length,
    input  output_queue_data_out,
    input  output_queue_ready
  );

  modport slave (
    input  output_queue_index,
    input  output_queue_get,
    output output_queue_length,
    output output_queue_data_out,
    output output_queue_ready
  );
endinterface

// File: rtl/fixed_point_alu.sv
// Combinational saturating fixed-point ALU; a is second-from-top, b is top of stack.
module fixed_point_alu
  import stack_machine_pkg::*;
#(
  parameter int INTEGER_PART_WIDTH    = DEF_INT_W,
  parameter int FRACTIONAL_PART_WIDTH = DEF_FRAC_W
) (
  input  logic [2:0]                                                   op,
  input  logic signed [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0]   a,
  input  logic signed [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0]   b,
  output logic signed [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0]   y
);
  localparam int N  = fp_width(INTEGER_PART_WIDTH, FRACTIONAL_PART_WIDTH);
  localparam int W2 = 2 * N;
  localparam logic signed [63:0]   MAX64 = sat_max(N);
  localparam logic signed [63:0]   MIN64 = sat_min(N);
  localparam logic signed [W2-1:0] MAXV  = MAX64[W2-1:0];
  localparam logic signed [W2-1:0] MINV  = MIN64[W2-1:0];

  function automatic logic signed [N-1:0] saturate(input logic signed [W2-1:0] v);
    if (v > MAXV) return MAXV[N-1:0];
    if (v < MINV) return MINV[N-1:0];
    return v[N-1:0];
  endfunction

  logic signed [W2-1:0] a_w, b_w, prod;

  // Operands widened to 2N so add/sub/neg never wrap before saturation.
  always_comb begin
    a_w  = W2'(a);
    b_w  = W2'(b);
    prod = a_w * b_w;
    case (op)
      OP_ADD:  y = saturate(a_w + b_w);
      OP_SUB:  y = saturate(a_w - b_w);
      OP_MUL:  y = saturate(prod >>> FRACTIONAL_PART_WIDTH);
      OP_NEG:  y = saturate(-b_w);
      default: y = b;
    endcase
  end

endmodule

// File: rtl/rpn_stack_evaluator.sv
// Postfix token evaluator: fetches tokens from the output queue one at a time,
// runs them on a register-array stack and reports y or an error code.
module rpn_stack_evaluator
  import stack_machine_pkg::*;
#(
  parameter int INTEGER_PART_WIDTH    = DEF_INT_W,
  parameter int FRACTIONAL_PART_WIDTH = DEF_FRAC_W,
  parameter int OUTPUT_QUEUE_SIZE     = 64,
  parameter int STACK_DEPTH           = 16
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic                                                       start,
  output logic                                                       ready,
  input  logic signed [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] x_input,
  output logic signed [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] y_output,
  output logic                                                       error,
  output logic [2:0]                                                 error_code,
  rpn_stack_evaluator_if.master                                      q
);
  localparam int N     = fp_width(INTEGER_PART_WIDTH, FRACTIONAL_PART_WIDTH);
  localparam int IDX_W = $clog2(OUTPUT_QUEUE_SIZE);
  localparam int LEN_W = $clog2(OUTPUT_QUEUE_SIZE + 1);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int SI_W  = $clog2(STACK_DEPTH);

  state_t             state_q, state_d;
  logic               ready_q, ready_d, err_q, err_d, get_q, get_d;
  logic [2:0]         code_q, code_d;
  logic signed [N-1:0] y_q, y_d, x_q, x_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [N:0]         tok_q, tok_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic signed [N-1:0] stack_q [STACK_DEPTH];
  logic signed [N-1:0] stack_d [STACK_DEPTH];

  logic [SI_W-1:0]    top_idx, sec_idx;
  logic [N-1:0]       opcode;
  logic               is_push, is_binary, is_neg, fault;
  logic [2:0]         fault_code;
  logic signed [N-1:0] alu_y, push_val;

  assign top_idx   = SI_W'(sp_q - 1'b1);
  assign sec_idx   = SI_W'(sp_q - 2'd2);
  assign opcode    = tok_q[N-1:0];
  assign is_push   = !tok_q[N] || (opcode == N'(OP_PUSHX));
  assign is_binary = tok_q[N] && ((opcode == N'(OP_ADD)) || (opcode == N'(OP_SUB)) ||
                                  (opcode == N'(OP_MUL)));
  assign is_neg    = tok_q[N] && (opcode == N'(OP_NEG));
  assign push_val  = tok_q[N] ? x_q : signed'(tok_q[N-1:0]);

  fixed_point_alu #(
    .INTEGER_PART_WIDTH   (INTEGER_PART_WIDTH),
    .FRACTIONAL_PART_WIDTH(FRACTIONAL_PART_WIDTH)
  ) u_alu (
    .op(tok_q[2:0]),
    .a (stack_q[sec_idx]),
    .b (stack_q[top_idx]),
    .y (alu_y)
  );

  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    err_d      = err_q;
    code_d     = code_q;
    y_d        = y_q;
    x_d        = x_q;
    len_d      = len_q;
    idx_d      = idx_q;
    get_d      = 1'b0;
    tok_d      = tok_q;
    sp_d       = sp_q;
    stack_d    = stack_q;
    fault      = 1'b0;
    fault_code = ERR_NONE;
    case (state_q)
      S_IDLE: if (start) begin
        x_d     = x_input;
        len_d   = q.output_queue_length;
        ready_d = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        sp_d  = '0;
        idx_d = '0;
        if (len_q == '0) begin
          fault      = 1'b1;
          fault_code = ERR_EMPTY;
        end else begin
          get_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: if (q.output_queue_ready) begin
        tok_d   = q.output_queue_data_out;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_push) begin
          if (sp_q == SP_W'(STACK_DEPTH)) begin
            fault      = 1'b1;
            fault_code = ERR_OVERFLOW;
          end else begin
            stack_d[SI_W'(sp_q)] = push_val;
            sp_d                 = sp_q + 1'b1;
          end
        end else if (is_binary) begin
          if (sp_q < SP_W'(2)) begin
            fault      = 1'b1;
            fault_code = ERR_UNDERFLOW;
          end else begin
            stack_d[sec_idx] = alu_y;
            sp_d             = sp_q - 1'b1;
          end
        end else if (is_neg) begin
          if (sp_q == '0) begin
            fault      = 1'b1;
            fault_code = ERR_UNDERFLOW;
          end else begin
            stack_d[top_idx] = alu_y;
          end
        end else begin
          fault      = 1'b1;
          fault_code = ERR_OPCODE;
        end
        // Index only advances when another fetch follows, so it stays stable through EXEC.
        if (!fault) begin
          if (LEN_W'(idx_q) + 1'b1 == len_q) begin
            state_d = S_CHECK;
          end else begin
            idx_d   = idx_q + 1'b1;
            get_d   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_CHECK: begin
        if (sp_q == SP_W'(1)) begin
          ready_d = 1'b1;
          y_d     = stack_q[0];
          err_d   = 1'b0;
          code_d  = ERR_NONE;
          state_d = S_IDLE;
        end else begin
          fault      = 1'b1;
          fault_code = ERR_MALFORMED;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fault) begin
      state_d = S_IDLE;
      ready_d = 1'b1;
      y_d     = '0;
      err_d   = 1'b1;
      code_d  = fault_code;
      get_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      y_q     <= '0;
      idx_q   <= '0;
      get_q   <= 1'b0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      code_q  <= code_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      get_q   <= get_d;
      sp_q    <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q     <= x_d;
    len_q   <= len_d;
    tok_q   <= tok_d;
    stack_q <= stack_d;
  end

  assign ready                = ready_q;
  assign y_output             = y_q;
  assign error                = err_q;
  assign error_code           = code_q;
  assign q.output_queue_index = idx_q;
  assign q.output_queue_get   = get_q;

endmodule
